// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between the ALU and a valid/ready data memory port
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [REG_WIDTH-1:0] addr,
  input  logic [REG_WIDTH-1:0] store_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [2:0]           funct3,
  output logic                 stall,
  output logic [REG_WIDTH-1:0] load_data,
  output logic                 misalign,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [REG_WIDTH-1:0] mem_req_addr,
  output logic                 mem_req_we,
  output logic [3:0]           mem_req_be,
  output logic [REG_WIDTH-1:0] mem_req_wdata,
  input  logic                 mem_rsp_valid,
  input  logic [REG_WIDTH-1:0] mem_rsp_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     off_q;
  logic [2:0]     f3_q;
  logic           load_q;
  logic           access;
  logic           mis_trap;
  logic [3:0]     be_nxt;
  logic [REG_WIDTH-1:0] wdata_nxt;
  logic [REG_WIDTH-1:0] lane_shift;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [REG_WIDTH-1:0] ext_data;

  assign access = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0]==01 is a half; 10/11 are treated as word
  assign mis_trap = ((funct3[1:0] == 2'b01) & addr[0]) |
                    (funct3[1] & (addr[1:0] != 2'b00));
`else
  assign mis_trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (access) state_nxt = mis_trap ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nxt = load_q ? WAIT : DONE;
      WAIT: if (mem_rsp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req_valid = (state == REQ);
  assign stall         = access & (state != DONE);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {addr[1], 1'b0};
        wdata_nxt = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction uses the offset latched at request time
  always_comb begin
    lane_shift = mem_rsp_rdata >> {off_q, 3'b000};
    lane_b     = lane_shift[7:0];
    lane_h     = off_q[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (f3_q)
      3'b000:  ext_data = {{(REG_WIDTH-8){lane_b[7]}}, lane_b};
      3'b001:  ext_data = {{(REG_WIDTH-16){lane_h[15]}}, lane_h};
      3'b100:  ext_data = {{(REG_WIDTH-8){1'b0}}, lane_b};
      3'b101:  ext_data = {{(REG_WIDTH-16){1'b0}}, lane_h};
      default: ext_data = mem_rsp_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      load_q        <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_be    <= 4'b0000;
      mem_req_wdata <= '0;
      load_data     <= '0;
    end else begin
      if (state == IDLE && access && !mis_trap) begin
        off_q         <= addr[1:0];
        f3_q          <= funct3;
        load_q        <= mem_read;
        mem_req_addr  <= {addr[REG_WIDTH-1:2], 2'b00};
        mem_req_we    <= mem_write;
        mem_req_be    <= be_nxt;
        mem_req_wdata <= wdata_nxt;
      end
      if (state == WAIT && mem_rsp_valid) load_data <= ext_data;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // High only for the DONE cycle entered straight from IDLE by a trap
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) misalign <= 1'b0;
    else          misalign <= (state == IDLE) & access & mis_trap;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the 32-bit ALU in the single-cycle core. It takes the ALU result as the effective address and drives a valid/ready data-memory port. It stalls the core until the access completes, then returns size- and sign-adjusted load data to the write-back mux. It replaces the ideal zero-latency data memory so that the core can use a multi-cycle memory.

## Interface
- REG_WIDTH, 32: data/address width; must equal the register-file and ALU width (only 32 supported).
- clk  input  1  single clock, rising edge.
- reset_b  input  1  asynchronous, active-low reset.
- addr  input  REG_WIDTH  effective address from ALU result.
- store_data  input  REG_WIDTH  rs2 value for stores.
- mem_read  input  1  current instruction is a load.
- mem_write  input  1  current instruction is a store. Never asserted together with mem_read.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 (stores).
- stall  output  1  holds PC/register-file write while the access is in flight.
- load_data  output  REG_WIDTH  extended load result, valid in DONE.
- misalign  output  1  misaligned access detected (only with the macro enabled; else tied 0).
- mem_req_valid  output  1  request valid to data memory.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  REG_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_req_we  output  1  1 = write.
- mem_req_be  output  4  byte enables.
- mem_req_wdata  output  REG_WIDTH  lane-replicated store data.
- mem_rsp_valid  input  1  read data valid (loads only; memory never responds to writes).
- mem_rsp_rdata  input  REG_WIDTH  read word.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on (mem_read|mem_write), latch addr[1:0], funct3, type, and the request fields, then go to REQ. Otherwise stay.
- REQ: mem_req_valid=1. Request fields are registered and stable until accepted. On mem_req_ready: a store goes to DONE; a load goes to WAIT.
- WAIT: on mem_rsp_valid, capture the extended data into load_data and go to DONE.
- DONE: one cycle, then go to IDLE. The core retires the instruction at the end of this cycle. The next instruction is evaluated in IDLE.
- stall = (mem_read|mem_write) & (state != DONE). This is combinational, so it is high in the first IDLE cycle.
- Byte enables:
  - b: 4'b0001 << addr[1:0].
  - h: 4'b0011 << {addr[1],1'b0}.
  - w: 4'b1111.
- Store data replication:
  - b: {4{sd[7:0]}}.
  - h: {2{sd[15:0]}}.
  - w: sd.
- Load extraction: select the lane by the latched addr[1:0]. b/h are sign-extended; bu/hu are zero-extended; w is passed through.
- Undefined funct3 on a load behaves as w. On a store, upper funct3 bits are ignored.
- load_data holds its value until the next load captures.

## Timing
- Reset values: state IDLE, mem_req_valid 0, mem_req_we 0, mem_req_be 0, mem_req_addr 0, mem_req_wdata 0, load_data 0, misalign 0. stall follows its equation.
- Minimum store latency: 3 cycles (IDLE, REQ with ready=1, DONE).
- Minimum load latency: 4 cycles (IDLE, REQ, WAIT with rsp, DONE).
- A response in the same cycle as acceptance is not allowed: memory responds at least one cycle after acceptance.
- mem_rsp_valid outside WAIT is ignored.
- Reset asserted mid-access: immediate return to IDLE with all outputs at reset values. The in-flight request is dropped, with no retry.
- mem_req_ready held low: stay in REQ indefinitely with stall high.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned half (addr[0]=1) or word (addr[1:0]!=0) access in IDLE goes directly to DONE without a memory request.
  - misalign=1 for that DONE cycle only.
  - load_data is unchanged.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Half accesses use addr[1] only.
  - Word accesses ignore addr[1:0].

## Test plan
- sw, addr=0x100, sd=0xDEADBEEF, ready=1 -> one request with addr 0x100, be=1111, wdata 0xDEADBEEF, we=1; stall high 2 cycles, low in DONE.
- sb, addr=0x103, sd=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, addr 0x100.
- lb, addr=0x102, rdata=0x1280FF00 -> load_data=0xFFFFFF80. lbu on the same access -> 0x00000080. lhu, addr=0x102 -> 0x00001280.
- lw with ready low 5 cycles and rsp 3 cycles after accept -> mem_req_valid stable for 6 cycles, stall high throughout, load_data correct in DONE.
- reset_b pulsed low while in WAIT -> state IDLE, mem_req_valid 0, load_data 0. A later rsp_valid is ignored.
- LSU_MISALIGN_TRAP_EN: lw at 0x101 -> no mem_req_valid, misalign=1 for one cycle, stall low that cycle.
